// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline latch sequencer.
package pipeline_ctrl_pkg;

  // Controller states: normal flow, waiting on dcache, halted until reset.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // Default number of DWAIT cycles tolerated before flagging a dmem error.
  localparam int unsigned DWAIT_TIMEOUT = 1024;

  // Width of the DWAIT cycle counter; holds counts up to DWAIT_TIMEOUT-1.
  localparam int unsigned WAIT_W = 10;

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline latch sequencer: en/flush for IF/ID, ID/EX, EX/MEM, MEM/WB and PC,
// with dmem wait tracking, sticky halt/timeout flags and saturating perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = DWAIT_TIMEOUT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             mem_redirect,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic             dmem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t       state_q, state_d;
  logic              dmem_err_q, dmem_err_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic dmem_pend;
  logic halting;
  logic redirect_take;

  // Load-use hazard: load in ID/EX writes a register the IF/ID instruction reads.
  always_comb begin
    load_use = 1'b0;
    if (idex_dREN && (idex_rd != 5'd0) &&
        ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2))) begin
      load_use = 1'b1;
    end
  end

  assign dmem_pend = exmem_dREN | exmem_dWEN;
  assign halting   = (state_q == HALTED) | memwb_halt;

  // Next state and Mealy latch controls, highest-priority condition first.
  always_comb begin
    state_d       = RUN;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_en       = 1'b1;
    idex_flush    = 1'b0;
    exmem_en      = 1'b1;
    exmem_flush   = 1'b0;
    memwb_en      = 1'b1;
    memwb_flush   = 1'b0;
    halt          = 1'b0;
    redirect_take = 1'b0;
    if (halting) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halt     = 1'b1;
      state_d  = HALTED;
    end else if (dmem_pend) begin
      // Freeze the front of the pipe; MEM/WB takes a bubble until the hit.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      if (!dhit) begin
        memwb_flush = 1'b1;
        state_d     = DWAIT;
      end
    end else if (mem_redirect) begin
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
      redirect_take = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // Wait counter, sticky timeout flag and saturating perf counters.
  always_comb begin
    wait_cnt_d  = '0;
    dmem_err_d  = dmem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == DWAIT) && (state_d == DWAIT) && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else if ((state_q == DWAIT) && (state_d == DWAIT)) begin
      wait_cnt_d = wait_cnt_q;
    end
    if ((state_q == DWAIT) && !halting && (wait_cnt_q == WAIT_W'(TIMEOUT - 1))) begin
      dmem_err_d = 1'b1;
    end
    if (!halting && !pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (redirect_take && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      dmem_err_q  <= 1'b0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dmem_err_q  <= dmem_err_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign dmem_err  = dmem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
